// File: rtl/cpu_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_if
//
// Bundles the board-side controls, the breakpoint/PC compare inputs and the
// execution-control outputs of cpu_run_ctrl into one interface.
//
//   btn_step  raw single-step push button (asynchronous, bouncy)
//   sw_run    run switch level
//   sw_speed  run-rate select (period 2^(DIV_SHIFT + 2*sw_speed))
//   bp_en     breakpoint enable
//   bp_addr   breakpoint PC
//   pc        current CPU PC, fed back from the datapath
//   cpu_ce    one-cycle clock enable to the CPU
//   state     0 HALT, 1 RUN, 2 STEP, 3 BREAK
//   halted    high whenever state != RUN
//   bp_hit    one-cycle pulse when a breakpoint stops the run
//   inst_cnt  number of cpu_ce pulses since reset (wraps)
//
// Modports:
//   master  board / testbench side: drives the inputs, observes the outputs
//   slave   the controller itself
// -----------------------------------------------------------------------------
interface cpu_run_ctrl_if;
    logic        btn_step;
    logic        sw_run;
    logic [1:0]  sw_speed;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;

    logic        cpu_ce;
    logic [1:0]  state;
    logic        halted;
    logic        bp_hit;
    logic [31:0] inst_cnt;

    modport master (
        output btn_step, sw_run, sw_speed, bp_en, bp_addr, pc,
        input  cpu_ce, state, halted, bp_hit, inst_cnt
    );

    modport slave (
        input  btn_step, sw_run, sw_speed, bp_en, bp_addr, pc,
        output cpu_ce, state, halted, bp_hit, inst_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Execution controller for the 54-instruction CPU. Instead of a divided clock
// the CPU runs on the board clock and advances one instruction per cpu_ce
// pulse. Three ways of producing pulses:
//   - free run at a switch-selected rate,
//   - single step from a debounced push button,
//   - a PC breakpoint that stops the free run before the matching
//     instruction executes.
//
// Ports:
//   clk_in  board clock (single clock domain)
//   reset   synchronous, active-high; clears all state
//   bus     cpu_run_ctrl_if.slave -- switches, button, breakpoint, pc in;
//           cpu_ce, state, halted, bp_hit, inst_cnt out
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a new button level
//   DEBOUNCE_W       debounce counter width, 2^DEBOUNCE_W > DEBOUNCE_CYCLES
//   DIV_SHIFT        log2 of the run period at sw_speed = 0
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DEBOUNCE_W      = 20,
    parameter int DIV_SHIFT       = 18
) (
    input  logic          clk_in,
    input  logic          reset,
    cpu_run_ctrl_if.slave bus
);

    // Enough divider bits for the slowest rate, 2^(DIV_SHIFT + 6).
    localparam int DIV_W = DIV_SHIFT + 6;

    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

    localparam logic [DEBOUNCE_W-1:0] DB_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_W-1:0] DB_ONE  = DEBOUNCE_W'(1);
    localparam logic [DIV_W-1:0]      DIV_ONE = DIV_W'(1);

    // Low-bit mask selecting one run period: P-1 with P = 2^(DIV_SHIFT+2*speed).
    // At the slowest speed the shift equals the counter width and the mask
    // becomes all ones.
    function automatic logic [DIV_W-1:0] period_mask(input logic [1:0] speed);
        logic [DIV_W-1:0] ones;
        int unsigned      shamt;
        ones  = '1;
        shamt = DIV_SHIFT + 2 * int'(speed);
        return ~(ones << shamt);
    endfunction

    // ---------------------------------------------------------------------
    // Button synchronizer (stage p0 -> p1)
    // ---------------------------------------------------------------------
    logic btn_sync_p0;
    logic btn_sync_p1;

    // ---------------------------------------------------------------------
    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive
    // differing samples; emit step_req on an accepted press.
    // ---------------------------------------------------------------------
    logic                  db_level;
    logic [DEBOUNCE_W-1:0] db_cnt;
    logic                  step_req;
    logic                  db_differs;
    logic                  db_accept;

    assign db_differs = (btn_sync_p1 != db_level);
    assign db_accept  = db_differs && (db_cnt == DB_LAST);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
            db_level    <= 1'b0;
            db_cnt      <= '0;
            step_req    <= 1'b0;
        end else begin
            btn_sync_p0 <= bus.btn_step;
            btn_sync_p1 <= btn_sync_p0;
            step_req    <= 1'b0;
            if (!db_differs) begin
                db_cnt <= '0;
            end else if (db_accept) begin
                db_level <= btn_sync_p1;
                db_cnt   <= '0;
                // Only the press is a request; an accepted release is silent.
                step_req <= btn_sync_p1;
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Run-rate divider and run FSM
    // ---------------------------------------------------------------------
    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic             ce_q;
    logic             ce_nxt;
    logic             hit_q;
    logic             hit_nxt;
    logic             halted_q;
    logic             skip_q;
    logic             skip_nxt;
    logic [31:0]      inst_q;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] div_mask;
    logic             tick;
    logic             bp_match;

    // The divider value held during a RUN cycle is (cycles since entry - 1).
    // The pulse decision looks at the value the counter is about to take, so
    // cpu_ce is high in exactly the cycle whose counter value has all period
    // bits set (first pulse on the P-th cycle in RUN).
    assign div_nxt  = div_cnt + DIV_ONE;
    assign div_mask = period_mask(bus.sw_speed);
    assign tick     = ((div_nxt & div_mask) == div_mask);
    assign bp_match = bus.bp_en && (bus.pc == bus.bp_addr);

    always_comb begin
        state_nxt = state_q;
        ce_nxt    = 1'b0;
        hit_nxt   = 1'b0;
        skip_nxt  = skip_q;
        case (state_q)
            ST_HALT: begin
                // Run wins over a coincident step; the step is dropped.
                if (bus.sw_run) begin
                    state_nxt = ST_RUN;
                    skip_nxt  = 1'b1;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                    ce_nxt    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.sw_run) begin
                    state_nxt = ST_HALT;
                end else if (tick) begin
                    // skip lets the first tick after a resume execute the
                    // instruction sitting at the breakpoint address.
                    if (bp_match && !skip_q) begin
                        state_nxt = ST_BREAK;
                        hit_nxt   = 1'b1;
                    end else begin
                        ce_nxt   = 1'b1;
                        skip_nxt = 1'b0;
                    end
                end
            end
            ST_STEP: begin
                // With the run switch still up, park in BREAK rather than
                // silently resuming the free run.
                state_nxt = bus.sw_run ? ST_BREAK : ST_HALT;
            end
            default: begin
                if (!bus.sw_run) begin
                    state_nxt = ST_HALT;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                    ce_nxt    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= ST_HALT;
            ce_q     <= 1'b0;
            hit_q    <= 1'b0;
            halted_q <= 1'b1;
            skip_q   <= 1'b0;
            inst_q   <= '0;
            div_cnt  <= '0;
        end else begin
            state_q  <= state_nxt;
            ce_q     <= ce_nxt;
            hit_q    <= hit_nxt;
            halted_q <= (state_nxt != ST_RUN);
            skip_q   <= skip_nxt;
            if (ce_nxt) begin
                inst_q <= inst_q + 32'd1;
            end
            // Counts only while staying in RUN; entering RUN starts at zero.
            if ((state_q == ST_RUN) && (state_nxt == ST_RUN)) begin
                div_cnt <= div_nxt;
            end else begin
                div_cnt <= '0;
            end
        end
    end

    assign bus.cpu_ce   = ce_q;
    assign bus.state    = state_q;
    assign bus.halted   = halted_q;
    assign bus.bp_hit   = hit_q;
    assign bus.inst_cnt = inst_q;

endmodule
